tap_regs: RTL and testbench

TAP_REGS -- requirements
Module: tap_regs

---
 rtl/tap_pkg.sv | 37 +++
 rtl/tap_regs_if.sv | 28 ++
 rtl/tap_shift_reg.sv | 52 +++++
 rtl/tap_regs.sv | 135 +++++++++++++
 tb/tb_tap_regs.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tap_pkg.sv
// Shared TAP data-register constants: opcodes, IR capture pattern, defaults
// and the instruction-to-data-register decode.
package tap_pkg;

    localparam int          IR_LEN_DEF = 4;
    localparam logic [31:0] IDCODE_DEF = 32'h1000_0A6F;

    localparam logic [3:0] OP_IDCODE  = 4'h1;
    localparam logic [3:0] OP_USER    = 4'h2;
    localparam logic [3:0] OP_BYPASS  = 4'hF;
    localparam logic [3:0] IR_CAPTURE = 4'b0001;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_TLR,
        ACT_CAP_IR,
        ACT_CAP_DR,
        ACT_SH_IR,
        ACT_SH_DR,
        ACT_UPD_IR,
        ACT_UPD_DR
    } tap_act_e;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_e;

    // Any opcode that is not recognised falls through to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [31:0] op, input logic user_en);
        if (op == 32'(OP_IDCODE)) return SEL_IDCODE;
        if (user_en && (op == 32'(OP_USER))) return SEL_USER;
        return SEL_BYPASS;
    endfunction

endpackage

// File: rtl/tap_regs_if.sv
// TAP serial port and controller state flags shared between the TAP
// controller (master) and the instruction/data register block (slave).
interface tap_regs_if;

    logic tdi;
    logic test_logic_reset;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic tdo;
    logic tdo_en;

    modport master (
        output tdi, test_logic_reset, capture_ir, shift_ir, update_ir,
               capture_dr, shift_dr, update_dr,
        input  tdo, tdo_en
    );

    modport slave (
        input  tdi, test_logic_reset, capture_ir, shift_ir, update_ir,
               capture_dr, shift_dr, update_dr,
        output tdo, tdo_en
    );

endinterface

// File: rtl/tap_shift_reg.sv
// Generic capture/shift/update register: serial shift stage (right shift,
// sin into MSB) plus a parallel update stage; init reloads both reset values.
module tap_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_SR  = '0,
    parameter logic [WIDTH-1:0] RST_PAR = '0
) (
    input  logic             tclk,
    input  logic             trst,
    input  logic             init,
    input  logic             cap,
    input  logic             shift,
    input  logic             upd,
    input  logic             sin,
    input  logic [WIDTH-1:0] cap_val,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] par
);

    logic [WIDTH-1:0] sr_d, sr_q;
    logic [WIDTH-1:0] par_d, par_q;

    always_comb begin
        sr_d  = sr_q;
        par_d = par_q;
        if (init) begin
            sr_d  = RST_SR;
            par_d = RST_PAR;
        end else if (cap) begin
            sr_d = cap_val;
        end else if (shift) begin
            sr_d           = sr_q >> 1;
            sr_d[WIDTH-1]  = sin;
        end else if (upd) begin
            par_d = sr_q;
        end
    end

    always_ff @(posedge tclk) begin
        if (trst) begin
            sr_q  <= RST_SR;
            par_q <= RST_PAR;
        end else begin
            sr_q  <= sr_d;
            par_q <= par_d;
        end
    end

    assign sr  = sr_q;
    assign par = par_q;

endmodule

// File: rtl/tap_regs.sv
// TAP instruction and data registers (IR, IDCODE, BYPASS, optional USER).
// Define TAP_USER_DR_EN to build the USER data register and its outputs.
module tap_regs
    import tap_pkg::*;
#(
    parameter int          IR_LEN     = IR_LEN_DEF,
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEF,
    parameter int          USER_LEN   = 8
) (
    input  logic                tclk,
    input  logic                trst,
    tap_regs_if.slave           tap,
    input  logic [USER_LEN-1:0] user_in,
    output logic [IR_LEN-1:0]   ir,
    output logic [USER_LEN-1:0] user_out,
    output logic                user_upd
);

`ifdef TAP_USER_DR_EN
    localparam logic USER_EN = 1'b1;
`else
    localparam logic USER_EN = 1'b0;
`endif

    tap_act_e              act;
    dr_sel_e               sel;
    logic [IR_LEN-1:0]     ir_sr;
    logic [31:0]           idcode_sr;
    logic [31:0]           idcode_par_unused;
    logic [USER_LEN-1:0]   user_sr;
    logic                  bypass_d, bypass_q;
    logic                  dr_lsb;

    // Flags are nominally one-hot; resolve overlaps to a single action.
    always_comb begin
        act = ACT_NONE;
        if      (tap.test_logic_reset) act = ACT_TLR;
        else if (tap.capture_ir)       act = ACT_CAP_IR;
        else if (tap.capture_dr)       act = ACT_CAP_DR;
        else if (tap.shift_ir)         act = ACT_SH_IR;
        else if (tap.shift_dr)         act = ACT_SH_DR;
        else if (tap.update_ir)        act = ACT_UPD_IR;
        else if (tap.update_dr)        act = ACT_UPD_DR;
    end

    assign sel = decode_ir(32'(ir), USER_EN);

    tap_shift_reg #(
        .WIDTH   (IR_LEN),
        .RST_SR  (IR_LEN'(IR_CAPTURE)),
        .RST_PAR (IR_LEN'(OP_IDCODE))
    ) u_ir (
        .tclk    (tclk),
        .trst    (trst),
        .init    (act == ACT_TLR),
        .cap     (act == ACT_CAP_IR),
        .shift   (act == ACT_SH_IR),
        .upd     (act == ACT_UPD_IR),
        .sin     (tap.tdi),
        .cap_val (IR_LEN'(IR_CAPTURE)),
        .sr      (ir_sr),
        .par     (ir)
    );

    tap_shift_reg #(.WIDTH(32)) u_idcode (
        .tclk    (tclk),
        .trst    (trst),
        .init    (1'b0),
        .cap     ((act == ACT_CAP_DR) && (sel == SEL_IDCODE)),
        .shift   ((act == ACT_SH_DR) && (sel == SEL_IDCODE)),
        .upd     (1'b0),
        .sin     (tap.tdi),
        .cap_val (IDCODE_VAL),
        .sr      (idcode_sr),
        .par     (idcode_par_unused)
    );

    always_comb begin
        bypass_d = bypass_q;
        if ((act == ACT_CAP_DR) && (sel == SEL_BYPASS))
            bypass_d = 1'b0;
        else if ((act == ACT_SH_DR) && (sel == SEL_BYPASS))
            bypass_d = tap.tdi;
    end

    always_ff @(posedge tclk) begin
        if (trst) bypass_q <= 1'b0;
        else      bypass_q <= bypass_d;
    end

`ifdef TAP_USER_DR_EN
    logic user_upd_d, user_upd_q;

    tap_shift_reg #(.WIDTH(USER_LEN)) u_user (
        .tclk    (tclk),
        .trst    (trst),
        .init    (1'b0),
        .cap     ((act == ACT_CAP_DR) && (sel == SEL_USER)),
        .shift   ((act == ACT_SH_DR) && (sel == SEL_USER)),
        .upd     ((act == ACT_UPD_DR) && (sel == SEL_USER)),
        .sin     (tap.tdi),
        .cap_val (user_in),
        .sr      (user_sr),
        .par     (user_out)
    );

    always_comb user_upd_d = (act == ACT_UPD_DR) && (sel == SEL_USER);

    always_ff @(posedge tclk) begin
        if (trst) user_upd_q <= 1'b0;
        else      user_upd_q <= user_upd_d;
    end

    assign user_upd = user_upd_q;
`else
    logic unused_user_in;
    assign unused_user_in = ^user_in;
    assign user_sr        = '0;
    assign user_out       = '0;
    assign user_upd       = 1'b0;
`endif

    always_comb begin
        case (sel)
            SEL_IDCODE: dr_lsb = idcode_sr[0];
            SEL_USER:   dr_lsb = user_sr[0];
            default:    dr_lsb = bypass_q;
        endcase
    end

    // tdo only sees flop outputs; tdi reaches it one shift later at the earliest.
    assign tap.tdo_en = (tap.shift_ir | tap.shift_dr) & ~trst;
    assign tap.tdo    = tap.tdo_en & (tap.shift_ir ? ir_sr[0] : dr_lsb);

endmodule

// File: tb/tb_tap_regs.sv
// Self-checking bench for tap_regs: directed scenarios plus randomized flag
// traffic, compared against a queue-based model of the TAP registers.
module tb_tap_regs;

    localparam int IRL = 4;
    localparam int UL  = 8;
`ifdef TAP_USER_DR_EN
    localparam bit USER_ON = 1'b1;
`else
    localparam bit USER_ON = 1'b0;
`endif

    localparam logic [6:0] F_NONE = 7'b000_0000;
    localparam logic [6:0] F_TLR  = 7'b100_0000;
    localparam logic [6:0] F_CIR  = 7'b010_0000;
    localparam logic [6:0] F_SIR  = 7'b001_0000;
    localparam logic [6:0] F_UIR  = 7'b000_1000;
    localparam logic [6:0] F_CDR  = 7'b000_0100;
    localparam logic [6:0] F_SDR  = 7'b000_0010;
    localparam logic [6:0] F_UDR  = 7'b000_0001;

    logic           tclk = 1'b0;
    logic           trst;
    logic [UL-1:0]  user_in;
    logic [UL-1:0]  user_out;
    logic [IRL-1:0] ir;
    logic           user_upd;

    tap_regs_if tap ();

    tap_regs #(
        .IR_LEN     (IRL),
        .IDCODE_VAL (32'h1000_0A6F),
        .USER_LEN   (UL)
    ) dut (
        .tclk     (tclk),
        .trst     (trst),
        .tap      (tap),
        .user_in  (user_in),
        .ir       (ir),
        .user_out (user_out),
        .user_upd (user_upd)
    );

    always #5 tclk = ~tclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each shift register is a bit queue, front = bit nearest tdo.
    bit          m_ir_sr[$];
    bit          m_byp[$];
    bit          m_idc[$];
    bit          m_usr[$];
    int unsigned m_ir;
    int unsigned m_uout;
    bit          m_upd;

    function automatic int m_sel();
        if (m_ir == 1) return 1;
        if (USER_ON && m_ir == 2) return 2;
        return 0;
    endfunction

    function automatic void ir_cap();
        m_ir_sr.delete();
        m_ir_sr.push_back(1'b1);
        for (int i = 1; i < IRL; i++) m_ir_sr.push_back(1'b0);
    endfunction

    function automatic void q_load(input int s, input logic [31:0] v);
        int n = (s == 0) ? 1 : ((s == 1) ? 32 : UL);
        bit q[$];
        for (int i = 0; i < n; i++) q.push_back(v[i]);
        case (s)
            0:       m_byp = q;
            1:       m_idc = q;
            default: m_usr = q;
        endcase
    endfunction

    function automatic void q_shift(input int s, input bit d);
        case (s)
            0:       begin void'(m_byp.pop_front()); m_byp.push_back(d); end
            1:       begin void'(m_idc.pop_front()); m_idc.push_back(d); end
            default: begin void'(m_usr.pop_front()); m_usr.push_back(d); end
        endcase
    endfunction

    function automatic bit q_front(input int s);
        case (s)
            0:       return m_byp[0];
            1:       return m_idc[0];
            default: return m_usr[0];
        endcase
    endfunction

    function automatic int unsigned q_to_int(input bit q[$]);
        int unsigned v = 0;
        for (int i = 0; i < q.size(); i++) if (q[i]) v += (32'd1 << i);
        return v;
    endfunction

    function automatic bit m_tdo(input logic [6:0] f, input bit rst);
        if (rst || !(f[4] || f[1])) return 1'b0;
        if (f[4]) return m_ir_sr[0];
        return q_front(m_sel());
    endfunction

    function automatic void m_edge(input logic [6:0] f, input bit d, input bit rst,
                                   input logic [31:0] uin);
        int s = m_sel();
        m_upd = 1'b0;
        if (rst) begin
            ir_cap();
            m_ir = 1;
            q_load(0, 0);
            q_load(1, 0);
            q_load(2, 0);
            m_uout = 0;
            return;
        end
        if (f[6]) begin
            m_ir = 1;
            ir_cap();
        end else if (f[5]) begin
            ir_cap();
        end else if (f[2]) begin
            q_load(s, (s == 0) ? 32'd0 : ((s == 1) ? 32'h1000_0A6F : uin));
        end else if (f[4]) begin
            void'(m_ir_sr.pop_front());
            m_ir_sr.push_back(d);
        end else if (f[1]) begin
            q_shift(s, d);
        end else if (f[3]) begin
            m_ir = q_to_int(m_ir_sr);
        end else if (f[0] && s == 2) begin
            m_uout = q_to_int(m_usr);
            m_upd  = 1'b1;
        end
    endfunction

    task automatic cyc(input logic [6:0] f, input bit d, input bit rst, output bit so);
        {tap.test_logic_reset, tap.capture_ir, tap.shift_ir, tap.update_ir,
         tap.capture_dr, tap.shift_dr, tap.update_dr} = f;
        tap.tdi = d;
        trst    = rst;
        @(negedge tclk);
        chk("tdo_en", tap.tdo_en, !rst && (f[4] || f[1]));
        chk("tdo", tap.tdo, m_tdo(f, rst));
        so = tap.tdo;
        @(posedge tclk);
        m_edge(f, d, rst, 32'(user_in));
        #1;
        chk("ir", ir, m_ir);
        chk("user_out", user_out, m_uout);
        chk("user_upd", user_upd, m_upd);
    endtask

    task automatic load_ir(input logic [IRL-1:0] op);
        bit so;
        cyc(F_CIR, 1'b0, 1'b0, so);
        for (int i = 0; i < IRL; i++) cyc(F_SIR, op[i], 1'b0, so);
        cyc(F_UIR, 1'b0, 1'b0, so);
        chk("ir_load", ir, op);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit           so;
        logic [31:0]  word;
        logic [7:0]   pat, seen;
        logic [3:0]   bits4;
        logic [6:0]   f;
        logic [IRL-1:0] op;
        int           n;

        user_in = '0;
        trst    = 1'b1;
        tap.tdi = 1'b0;
        {tap.test_logic_reset, tap.capture_ir, tap.shift_ir, tap.update_ir,
         tap.capture_dr, tap.shift_dr, tap.update_dr} = F_NONE;

        // reset with shift flag held: outputs must still be quiet
        cyc(F_SDR, 1'b1, 1'b1, so);
        chk("rst_ir", ir, 1);
        chk("rst_user_out", user_out, 0);

        // IDCODE readout after reset
        cyc(F_CDR, 1'b0, 1'b0, so);
        word = '0;
        for (int i = 0; i < 32; i++) begin
            cyc(F_SDR, 1'($urandom_range(0, 1)), 1'b0, so);
            word[i] = so;
        end
        chk("idcode_word", word, 32'h1000_0A6F);

        // BYPASS one-cycle delay
        load_ir(4'hF);
        cyc(F_CDR, 1'b0, 1'b0, so);
        bits4 = 4'b1101;
        pat   = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(F_SDR, bits4[i], 1'b0, so);
            pat[i] = so;
        end
        chk("bypass_seq", pat[3:0], 4'b1010);

        // USER capture/shift/update (BYPASS when USER is not built)
        load_ir(4'h2);
        user_in = 8'hA5;
        cyc(F_CDR, 1'b0, 1'b0, so);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            cyc(F_SDR, pat[i], 1'b0, so);
            seen[i] = so;
        end
        chk("user_byte", seen, USER_ON ? 8'hA5 : 8'h78);
        cyc(F_UDR, 1'b0, 1'b0, so);
        chk("upd_pulse", user_upd, USER_ON);
        chk("upd_value", user_out, USER_ON ? 8'h3C : 8'h00);
        cyc(F_NONE, 1'b0, 1'b0, so);
        chk("upd_clear", user_upd, 0);

        // unknown opcode behaves as BYPASS
        load_ir(4'h7);
        cyc(F_CDR, 1'b0, 1'b0, so);
        pat = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            cyc(F_SDR, pat[i], 1'b0, so);
            seen[i] = so;
        end
        chk("op7_bypass", seen, {pat[6:0], 1'b0});

        // trst mid-shift aborts the USER transfer
        cyc(F_NONE, 1'b0, 1'b1, so);
        load_ir(4'h2);
        cyc(F_CDR, 1'b0, 1'b0, so);
        cyc(F_SDR, 1'b1, 1'b0, so);
        cyc(F_SDR, 1'b1, 1'b0, so);
        cyc(F_SDR, 1'b1, 1'b1, so);
        cyc(F_UDR, 1'b0, 1'b0, so);
        chk("trst_ir", ir, 1);
        chk("trst_user_out", user_out, 0);
        chk("trst_no_upd", user_upd, 0);

        // test_logic_reset wins over update_ir
        cyc(F_CIR, 1'b0, 1'b0, so);
        for (int i = 0; i < IRL; i++) cyc(F_SIR, 1'b1, 1'b0, so);
        cyc(F_TLR | F_UIR, 1'b0, 1'b0, so);
        chk("tlr_over_upd", ir, 1);

        // randomized structured transactions
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       op = 4'h1;
                1:       op = 4'h2;
                2:       op = 4'hF;
                default: op = 4'($urandom);
            endcase
            load_ir(op);
            user_in = 8'($urandom);
            cyc(F_CDR, 1'b0, 1'b0, so);
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) cyc(F_SDR, 1'($urandom_range(0, 1)), 1'b0, so);
            cyc(F_UDR, 1'b0, 1'b0, so);
            for (int i = 0; i < $urandom_range(0, 2); i++) cyc(F_NONE, 1'b0, 1'b0, so);
        end

        // free-running random flag traffic, including overlaps and trst
        for (int t = 0; t < 1500; t++) begin
            n = $urandom_range(0, 99);
            if (n < 70)      f = 7'(1 << $urandom_range(0, 5));
            else if (n < 85) f = F_NONE;
            else             f = 7'($urandom);
            if ($urandom_range(0, 15) == 0) user_in = 8'($urandom);
            cyc(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), so);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
